// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and defaults for the 2:1 stream arbiter front end
package mux_arb_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 16;

    typedef enum logic {ST_EMPTY, ST_FULL} out_state_t;

    localparam logic SEL_IN0 = 1'b0;
    localparam logic SEL_IN1 = 1'b1;
endpackage

// File: rtl/mux2_stream_arb_if.sv
// rtl/mux2_stream_arb_if.sv - two source streams, one selected output stream and grant counters
interface mux2_stream_arb_if
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);
    logic [WIDTH-1:0] in0_data;
    logic             in0_valid;
    logic             in0_ready;
    logic [WIDTH-1:0] in1_data;
    logic             in1_valid;
    logic             in1_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sel;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] gnt0_cnt;
    logic [CNT_W-1:0] gnt1_cnt;

    // master: sources and consumer around the arbiter
    modport master (
        output in0_data, in0_valid, in1_data, in1_valid, out_ready,
        input  in0_ready, in1_ready, out_data, out_sel, out_valid, gnt0_cnt, gnt1_cnt
    );

    // slave: the arbiter itself
    modport slave (
        input  in0_data, in0_valid, in1_data, in1_valid, out_ready,
        output in0_ready, in1_ready, out_data, out_sel, out_valid, gnt0_cnt, gnt1_cnt
    );
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin grant with the priority pointer flop
module rr_arb2
    import mux_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic       gnt_valid,
    output logic       gnt_idx
);
    logic ptr;

    // after a transfer the other source gets priority on the next contention
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= SEL_IN0;
        end else if (adv) begin
            ptr <= ~gnt_idx;
        end
    end

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = SEL_IN0;
        case (req)
            2'b01:   gnt_idx = SEL_IN0;
            2'b10:   gnt_idx = SEL_IN1;
            2'b11:   gnt_idx = ptr;
            default: gnt_idx = SEL_IN0;
        endcase
    end
endmodule

// File: rtl/mux2_stream_arb.sv
// rtl/mux2_stream_arb.sv - round-robin 2:1 stream mux with a 1-deep registered output stage
// Optional grant counters are built when MUX_ARB_CNT_EN is defined.
module mux2_stream_arb
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
)(
    input logic             clk,
    input logic             rst,
    mux2_stream_arb_if.slave bus
);
    out_state_t       state, state_nxt;
    logic             load;
    logic             gnt_valid;
    logic             gnt_idx;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       ({bus.in1_valid, bus.in0_valid}),
        .adv       (xfer),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // ready is gated by rst so nothing is accepted while the stage is held empty
    always_comb begin
        load          = (state == ST_EMPTY) | bus.out_ready;
        bus.in0_ready = !rst & load & gnt_valid & (gnt_idx == SEL_IN0);
        bus.in1_ready = !rst & load & gnt_valid & (gnt_idx == SEL_IN1);
        xfer          = bus.in0_ready | bus.in1_ready;
        sel_data      = (gnt_idx == SEL_IN1) ? bus.in1_data : bus.in0_data;
        state_nxt     = state;
        if (load) begin
            state_nxt = xfer ? ST_FULL : ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_data <= '0;
            bus.out_sel  <= SEL_IN0;
        end else if (xfer) begin
            bus.out_data <= sel_data;
            bus.out_sel  <= gnt_idx;
        end
    end

    assign bus.out_valid = (state == ST_FULL);

`ifdef MUX_ARB_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.gnt0_cnt <= '0;
            bus.gnt1_cnt <= '0;
        end else begin
            if (bus.in0_ready && bus.gnt0_cnt != '1) begin
                bus.gnt0_cnt <= bus.gnt0_cnt + CNT_W'(1);
            end
            if (bus.in1_ready && bus.gnt1_cnt != '1) begin
                bus.gnt1_cnt <= bus.gnt1_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign bus.gnt0_cnt = {CNT_W{1'b0}};
    assign bus.gnt1_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_mux2_stream_arb.sv
// tb/tb_mux2_stream_arb.sv - directed scoreboard bench for mux2_stream_arb
module tb_mux2_stream_arb;
    localparam int W  = 32;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    logic [W:0] sb[$];

    always #5 clk = ~clk;

    mux2_stream_arb_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    mux2_stream_arb #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag);
        logic [W:0] e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s observed=word expected=empty scoreboard", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
            chk(tag, 64'({bus.out_sel, bus.out_data}), 64'(e));
        end
    endtask

    function automatic logic [63:0] exp_cnt(input int n);
`ifdef MUX_ARB_CNT_EN
        return (n > 15) ? 64'd15 : 64'(n);
`else
        return (n > 0) ? 64'd0 : 64'd0;
`endif
    endfunction

    task automatic idle_inputs();
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
        bus.in0_data  = '0;
        bus.in1_data  = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        bus.out_ready = 1'b0;
        bus.in0_valid = 1'b1;
        bus.in1_valid = 1'b1;
        #3;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_in0_ready", 64'(bus.in0_ready), 64'd0);
        chk("rst_in1_ready", 64'(bus.in1_ready), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        idle_inputs();

        // single source
        bus.in0_valid = 1'b1;
        bus.in0_data  = 32'h2;
        bus.out_ready = 1'b1;
        sb.push_back({1'b0, 32'h2});
        #1;
        chk("single_in0_ready", 64'(bus.in0_ready), 64'd1);
        tick();
        bus.in0_valid = 1'b0;
        check_out("single");

        // drain
        tick();
        chk("drain_out_valid", 64'(bus.out_valid), 64'd0);
        chk("drain_out_data", 64'(bus.out_data), 64'h2);

        // load a word from in0 (ptr moves to 1), then reset mid-stream
        bus.out_ready = 1'b0;
        bus.in0_valid = 1'b1;
        bus.in0_data  = 32'h55;
        sb.push_back({1'b0, 32'h55});
        tick();
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b1;
        bus.in1_data  = 32'h9;
        check_out("preload");
        #1;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_out_data", 64'(bus.out_data), 64'd0);
        chk("arst_out_sel", 64'(bus.out_sel), 64'd0);
        chk("arst_in1_ready", 64'(bus.in1_ready), 64'd0);
        chk("arst_gnt0", 64'(bus.gnt0_cnt), 64'd0);
        sb.delete();
        tick();
        rst = 1'b0;
        idle_inputs();

        // contention: ptr must restart at 0
        bus.out_ready = 1'b1;
        bus.in0_valid = 1'b1;
        bus.in0_data  = 32'h7;
        bus.in1_valid = 1'b1;
        bus.in1_data  = 32'h3;
        sb.push_back({1'b0, 32'h7});
        sb.push_back({1'b1, 32'h3});
        sb.push_back({1'b0, 32'h7});
        sb.push_back({1'b1, 32'h3});
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out("contend");
        end
        bus.in0_valid = 1'b0;

        // backpressure with the last contention word (3, sel1) held
        bus.out_ready = 1'b0;
        bus.in1_data  = 32'h6;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in0_ready", 64'(bus.in0_ready), 64'd0);
            chk("bp_in1_ready", 64'(bus.in1_ready), 64'd0);
            chk("bp_hold", 64'({bus.out_valid, bus.out_sel, bus.out_data}), {31'd0, 1'b1, 1'b1, 32'h3});
            tick();
        end
        bus.out_ready = 1'b1;
        sb.push_back({1'b1, 32'h6});
        tick();
        bus.in1_valid = 1'b0;
        check_out("bp_release");
        chk("cnt_gnt0_mix", 64'(bus.gnt0_cnt), exp_cnt(2));
        chk("cnt_gnt1_mix", 64'(bus.gnt1_cnt), exp_cnt(3));

        // counter saturation after a fresh reset
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        bus.in0_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in0_data = 32'h100 + 32'(i);
            sb.push_back({1'b0, 32'h100 + 32'(i)});
            tick();
            check_out("stream");
            chk("cnt_gnt0", 64'(bus.gnt0_cnt), exp_cnt(i + 1));
        end
        bus.in0_valid = 1'b0;
        chk("cnt_gnt1_zero", 64'(bus.gnt1_cnt), 64'd0);
        tick();
        chk("final_drain", 64'(bus.out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
